// File: rtl/dt_pkg.sv
// Shared definitions for the decision-tree engine: width helpers, default sizes,
// node-word layout and FSM state encoding.
package dt_pkg;

    function automatic int width_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int DT_N_FEAT    = 51;
    localparam int DT_N_NODES   = 64;
    localparam int DT_N_CLASS   = 5;
    localparam int DT_MAX_DEPTH = 16;

    localparam int DT_FIDX_W  = width_of(DT_N_FEAT);
    localparam int DT_ADDR_W  = width_of(DT_N_NODES);
    localparam int DT_CLS_W   = width_of(DT_N_CLASS);
    localparam int DT_DEPTH_W = width_of(DT_MAX_DEPTH + 1);
    localparam int DT_NODE_W  = 1 + DT_FIDX_W + 2 * DT_ADDR_W;

    // Node word, MSB first: {internal, fidx, t_child, f_child}
    localparam int DT_F_CHILD_LSB = 0;
    localparam int DT_T_CHILD_LSB = DT_ADDR_W;
    localparam int DT_FIDX_LSB    = 2 * DT_ADDR_W;
    localparam int DT_INT_BIT     = 2 * DT_ADDR_W + DT_FIDX_W;

    typedef struct packed {
        logic                 internal;
        logic [DT_FIDX_W-1:0] fidx;
        logic [DT_ADDR_W-1:0] t_child;
        logic [DT_ADDR_W-1:0] f_child;
    } node_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WALK = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/dt_node_table.sv
// Register-array node memory: synchronous clear on reset, one write port,
// one combinational read port.
module dt_node_table
    import dt_pkg::*;
#(
    parameter int N_NODES = DT_N_NODES,
    parameter int ADDR_W  = DT_ADDR_W,
    parameter int NODE_W  = DT_NODE_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [NODE_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [NODE_W-1:0] rdata
);

    logic [NODE_W-1:0] mem [N_NODES];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_NODES; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/dt_tree_engine.sv
// Sequential decision-tree walker: one node per cycle from a loadable node table.
// Optional macro DT_DEPTH_OUT_EN adds the out_depth port (nodes visited per walk).
module dt_tree_engine
    import dt_pkg::*;
#(
    parameter int N_FEAT    = DT_N_FEAT,
    parameter int N_NODES   = DT_N_NODES,
    parameter int N_CLASS   = DT_N_CLASS,
    parameter int MAX_DEPTH = DT_MAX_DEPTH,
    parameter int ROOT      = 0,
    localparam int FIDX_W   = width_of(N_FEAT),
    localparam int ADDR_W   = width_of(N_NODES),
    localparam int CLS_W    = width_of(N_CLASS),
    localparam int DEPTH_W  = width_of(MAX_DEPTH + 1),
    localparam int NODE_W   = 1 + FIDX_W + 2 * ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N_FEAT-1:0] in_feat,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CLS_W-1:0]  out_class,
    output logic              out_err,
    input  logic              cfg_we,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [NODE_W-1:0] cfg_data,
    output logic              cfg_ready
`ifdef DT_DEPTH_OUT_EN
    ,
    output logic [DEPTH_W-1:0] out_depth
`endif
);

    localparam logic [ADDR_W-1:0]  ROOT_A     = ADDR_W'(ROOT % N_NODES);
    localparam logic [FIDX_W:0]    FEAT_LIM   = (FIDX_W + 1)'(N_FEAT);
    localparam logic [ADDR_W:0]    NODE_LIM   = (ADDR_W + 1)'(N_NODES);
    localparam logic [DEPTH_W-1:0] LAST_STEP  = DEPTH_W'(MAX_DEPTH - 1);
    localparam logic [DEPTH_W-1:0] FULL_DEPTH = DEPTH_W'(MAX_DEPTH);

    state_t              state;
    logic [N_FEAT-1:0]   feat_q;
    logic [ADDR_W-1:0]   node;
    logic [DEPTH_W-1:0]  step;
    logic [NODE_W-1:0]   node_word;
    logic                nd_internal;
    logic [FIDX_W-1:0]   nd_fidx;
    logic [ADDR_W-1:0]   nd_t;
    logic [ADDR_W-1:0]   nd_f;
    logic                feat_bit;
    logic [ADDR_W-1:0]   child;
    logic [ADDR_W-1:0]   next_node;

    dt_node_table #(
        .N_NODES (N_NODES),
        .ADDR_W  (ADDR_W),
        .NODE_W  (NODE_W)
    ) u_table (
        .clk   (clk),
        .rst   (rst),
        .we    (cfg_we && (state == ST_IDLE)),
        .waddr (cfg_addr),
        .wdata (cfg_data),
        .raddr (node),
        .rdata (node_word)
    );

    assign nd_internal = node_word[NODE_W-1];
    assign nd_fidx     = node_word[2*ADDR_W +: FIDX_W];
    assign nd_t        = node_word[ADDR_W +: ADDR_W];
    assign nd_f        = node_word[0 +: ADDR_W];

    // Out-of-range feature indices fall back to bit 0; child addresses wrap
    // modulo N_NODES (one subtraction suffices since child < 2*N_NODES).
    always_comb begin
        feat_bit = feat_q[0];
        if ({1'b0, nd_fidx} < FEAT_LIM) begin
            feat_bit = feat_q[nd_fidx];
        end
        child     = feat_bit ? nd_t : nd_f;
        next_node = child;
        if ({1'b0, child} >= NODE_LIM) begin
            next_node = child - NODE_LIM[ADDR_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            in_ready  <= 1'b1;
            cfg_ready <= 1'b1;
            out_valid <= 1'b0;
            out_class <= '0;
            out_err   <= 1'b0;
            feat_q    <= '0;
            node      <= ROOT_A;
            step      <= '0;
`ifdef DT_DEPTH_OUT_EN
            out_depth <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        feat_q    <= in_feat;
                        node      <= ROOT_A;
                        step      <= '0;
                        in_ready  <= 1'b0;
                        cfg_ready <= 1'b0;
                        state     <= ST_WALK;
                    end
                end
                ST_WALK: begin
                    if (!nd_internal) begin
                        out_class <= nd_t[CLS_W-1:0];
                        out_err   <= 1'b0;
`ifdef DT_DEPTH_OUT_EN
                        out_depth <= step + 1'b1;
`endif
                        state     <= ST_DONE;
                    end else if (step == LAST_STEP) begin
                        out_class <= '0;
                        out_err   <= 1'b1;
`ifdef DT_DEPTH_OUT_EN
                        out_depth <= FULL_DEPTH;
`endif
                        state     <= ST_DONE;
                    end else begin
                        node <= next_node;
                        step <= step + 1'b1;
                    end
                end
                // Result is raised one cycle after entering DONE, then held
                // until the consumer takes it.
                ST_DONE: begin
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        cfg_ready <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifndef DT_DEPTH_OUT_EN
    logic unused_full_depth;
    assign unused_full_depth = ^FULL_DEPTH;
`endif

endmodule

// File: tb/tb_dt_tree_engine.sv
// Randomized self-checking bench for dt_tree_engine against a table-walk reference model.
module tb_dt_tree_engine;
    import dt_pkg::*;

    localparam int NF = 51;
    localparam int NN = 64;
    localparam int MD = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [50:0] in_feat = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [2:0]  out_class;
    logic        out_err;
    logic        cfg_we = 1'b0;
    logic [5:0]  cfg_addr = '0;
    logic [18:0] cfg_data = '0;
    logic        cfg_ready;
`ifdef DT_DEPTH_OUT_EN
    logic [4:0]  out_depth;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    node_t mdl [NN];

    dt_tree_engine #(
        .N_FEAT(NF), .N_NODES(NN), .N_CLASS(5), .MAX_DEPTH(MD), .ROOT(0)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_feat(in_feat),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_class(out_class), .out_err(out_err),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .cfg_ready(cfg_ready)
`ifdef DT_DEPTH_OUT_EN
        , .out_depth(out_depth)
`endif
    );

    always #5 clk = ~clk;

    function automatic node_t mk(input bit internal, input int fidx, input int t, input int f);
        node_t n;
        n.internal = internal;
        n.fidx     = 6'(fidx);
        n.t_child  = 6'(t);
        n.f_child  = 6'(f);
        return n;
    endfunction

    function automatic logic [50:0] rand_feat();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[50:0];
    endfunction

    // Reference: follow the tree from the root using the node rules directly.
    function automatic void model_walk(input logic [50:0] f, output logic [2:0] cls,
                                       output logic err, output int depth);
        int    n;
        node_t nd;
        bit    b;
        n = 0; cls = '0; err = 1'b0; depth = 0;
        for (int s = 0; s < MD; s++) begin
            nd = mdl[n];
            depth = s + 1;
            if (!nd.internal) begin
                cls = nd.t_child[2:0];
                return;
            end
            b = (int'(nd.fidx) < NF) ? f[nd.fidx] : f[0];
            n = (b ? int'(nd.t_child) : int'(nd.f_child)) % NN;
        end
        err = 1'b1; cls = '0; depth = MD;
    endfunction

    task automatic do_reset();
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        for (int i = 0; i < NN; i++) mdl[i] = '0;
    endtask

    task automatic cfg_write(input int addr, input node_t d);
        @(negedge clk);
        cfg_we = 1'b1; cfg_addr = 6'(addr); cfg_data = d;
        @(negedge clk);
        cfg_we = 1'b0;
        mdl[addr] = d;
    endtask

    task automatic load_tree();
        cfg_write(0, mk(1, 50, 1, 2));
        cfg_write(1, mk(0, 0, 3, 0));
        cfg_write(2, mk(1, 13, 3, 4));
        cfg_write(3, mk(0, 0, 1, 0));
        cfg_write(4, mk(0, 0, 4, 0));
    endtask

    task automatic start_walk(input logic [50:0] f);
        @(negedge clk);
        in_valid = 1'b1; in_feat = f;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_result(output int lat, output logic [2:0] cls,
                               output logic err, output logic [4:0] dep);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        if (out_valid !== 1'b1) begin
            n_checks++; n_fail++;
            $display("FAIL walk_timeout: out_valid=%b after %0d cycles, want 1", out_valid, lat);
        end
        cls = out_class; err = out_err;
`ifdef DT_DEPTH_OUT_EN
        dep = out_depth;
`else
        dep = '0;
`endif
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        int lat; logic [2:0] c; logic e; logic [4:0] d;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < NN; i++) mdl[i] = '0;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
        n_checks++; if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL rst_cfg_ready: got %b want 1", cfg_ready); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
        n_checks++; if (out_class !== 3'd0) begin n_fail++; $display("FAIL rst_out_class: got %0d want 0", out_class); end
        n_checks++; if (out_err !== 1'b0) begin n_fail++; $display("FAIL rst_out_err: got %b want 0", out_err); end
`ifdef DT_DEPTH_OUT_EN
        n_checks++; if (out_depth !== 5'd0) begin n_fail++; $display("FAIL rst_out_depth: got %0d want 0", out_depth); end
`endif
        start_walk(rand_feat());
        wait_result(lat, c, e, d);
        release_result();
        n_checks++; if (c !== 3'd0) begin n_fail++; $display("FAIL cleared_class: got %0d want 0", c); end
        n_checks++; if (lat != 2) begin n_fail++; $display("FAIL cleared_latency: got %0d want 2", lat); end
    endtask

    task automatic test_tree();
        int lat; logic [2:0] c; logic e; logic [4:0] d;
        logic [50:0] f; logic [2:0] mc; logic me; int md;
        do_reset();
        load_tree();
        for (int k = 0; k < 3; k++) begin
            f = rand_feat();
            f[50] = (k == 0);
            f[13] = (k == 2);
            model_walk(f, mc, me, md);
            start_walk(f);
            wait_result(lat, c, e, d);
            release_result();
            n_checks++; if (c !== mc) begin n_fail++; $display("FAIL tree_class[%0d]: got %0d want %0d", k, c, mc); end
            n_checks++; if (e !== me) begin n_fail++; $display("FAIL tree_err[%0d]: got %b want %b", k, e, me); end
            n_checks++; if (lat != md + 1) begin n_fail++; $display("FAIL tree_latency[%0d]: got %0d want %0d", k, lat, md + 1); end
        end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL tree_idle_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_root_leaf();
        int lat; logic [2:0] c; logic e; logic [4:0] d;
        do_reset();
        cfg_write(0, mk(0, 0, 2, 0));
        start_walk(rand_feat());
        wait_result(lat, c, e, d);
        release_result();
        n_checks++; if (c !== 3'd2) begin n_fail++; $display("FAIL root_leaf_class: got %0d want 2", c); end
        n_checks++; if (e !== 1'b0) begin n_fail++; $display("FAIL root_leaf_err: got %b want 0", e); end
        n_checks++; if (lat != 2) begin n_fail++; $display("FAIL root_leaf_latency: got %0d want 2", lat); end
`ifdef DT_DEPTH_OUT_EN
        n_checks++; if (d !== 5'd1) begin n_fail++; $display("FAIL root_leaf_depth: got %0d want 1", d); end
`endif
    endtask

    task automatic test_self_loop();
        int lat; logic [2:0] c; logic e; logic [4:0] d;
        do_reset();
        cfg_write(0, mk(1, 0, 0, 0));
        start_walk(rand_feat());
        wait_result(lat, c, e, d);
        release_result();
        n_checks++; if (e !== 1'b1) begin n_fail++; $display("FAIL loop_err: got %b want 1", e); end
        n_checks++; if (c !== 3'd0) begin n_fail++; $display("FAIL loop_class: got %0d want 0", c); end
        n_checks++; if (lat != MD + 1) begin n_fail++; $display("FAIL loop_latency: got %0d want %0d", lat, MD + 1); end
`ifdef DT_DEPTH_OUT_EN
        n_checks++; if (d !== 5'(MD)) begin n_fail++; $display("FAIL loop_depth: got %0d want %0d", d, MD); end
`endif
    endtask

    task automatic test_hold();
        int lat; logic [2:0] c; logic e; logic [4:0] d;
        do_reset();
        cfg_write(0, mk(0, 0, 2, 0));
        start_walk(rand_feat());
        wait_result(lat, c, e, d);
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL hold_valid[%0d]: got %b want 1", i, out_valid); end
            n_checks++; if (out_class !== 3'd2) begin n_fail++; $display("FAIL hold_class[%0d]: got %0d want 2", i, out_class); end
            n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL hold_in_ready[%0d]: got %b want 0", i, in_ready); end
        end
        in_valid = 1'b0;
        release_result();
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL release_in_ready: got %b want 1", in_ready); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL release_out_valid: got %b want 0", out_valid); end
    endtask

    task automatic test_cfg_same_cycle();
        int lat; logic [2:0] c; logic e; logic [4:0] d;
        do_reset();
        @(negedge clk);
        cfg_we = 1'b1; cfg_addr = 6'd0; cfg_data = mk(0, 0, 5, 0);
        in_valid = 1'b1; in_feat = rand_feat();
        @(negedge clk);
        cfg_we = 1'b0; in_valid = 1'b0;
        wait_result(lat, c, e, d);
        release_result();
        n_checks++; if (c !== 3'd5) begin n_fail++; $display("FAIL same_cycle_class: got %0d want 5", c); end
        n_checks++; if (lat != 2) begin n_fail++; $display("FAIL same_cycle_latency: got %0d want 2", lat); end
    endtask

    task automatic test_cfg_during_walk();
        int lat; logic [2:0] c; logic e; logic [4:0] d;
        logic [50:0] f;
        do_reset();
        load_tree();
        f = rand_feat(); f[50] = 1'b1;
        start_walk(f);
        n_checks++; if (cfg_ready !== 1'b0) begin n_fail++; $display("FAIL walk_cfg_ready: got %b want 0", cfg_ready); end
        cfg_we = 1'b1; cfg_addr = 6'd1; cfg_data = mk(0, 0, 6, 0);
        @(negedge clk);
        cfg_we = 1'b0;
        wait_result(lat, c, e, d);
        release_result();
        n_checks++; if (c !== 3'd3) begin n_fail++; $display("FAIL ignored_write_class: got %0d want 3", c); end
        start_walk(f);
        wait_result(lat, c, e, d);
        release_result();
        n_checks++; if (c !== 3'd3) begin n_fail++; $display("FAIL ignored_write_next_class: got %0d want 3", c); end
    endtask

    task automatic test_reset_mid_walk();
        int lat; logic [2:0] c; logic e; logic [4:0] d;
        do_reset();
        cfg_write(0, mk(1, 0, 0, 0));
        start_walk(rand_feat());
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < NN; i++) mdl[i] = '0;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_out_valid: got %b want 0", out_valid); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_in_ready: got %b want 1", in_ready); end
        n_checks++; if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_cfg_ready: got %b want 1", cfg_ready); end
        start_walk(rand_feat());
        wait_result(lat, c, e, d);
        release_result();
        n_checks++; if (c !== 3'd0 || e !== 1'b0) begin n_fail++; $display("FAIL midrst_walk: got class %0d err %b want class 0 err 0", c, e); end
        n_checks++; if (lat != 2) begin n_fail++; $display("FAIL midrst_latency: got %0d want 2", lat); end
    endtask

    task automatic test_random_trees();
        int lat; logic [2:0] c; logic e; logic [4:0] d;
        logic [50:0] f; logic [2:0] mc; logic me; int md;
        for (int t = 0; t < 3; t++) begin
            do_reset();
            for (int n = 0; n < NN; n++) begin
                cfg_write(n, mk($urandom_range(0, 3) != 0, $urandom_range(0, 63),
                                $urandom_range(0, 63), $urandom_range(0, 63)));
            end
            for (int w = 0; w < 8; w++) begin
                f = rand_feat();
                model_walk(f, mc, me, md);
                start_walk(f);
                wait_result(lat, c, e, d);
                release_result();
                n_checks++; if (c !== mc || e !== me) begin n_fail++; $display("FAIL rand_result[%0d.%0d]: got class %0d err %b want class %0d err %b", t, w, c, e, mc, me); end
                n_checks++; if (lat != md + 1) begin n_fail++; $display("FAIL rand_latency[%0d.%0d]: got %0d want %0d", t, w, lat, md + 1); end
`ifdef DT_DEPTH_OUT_EN
                n_checks++; if (int'(d) != md) begin n_fail++; $display("FAIL rand_depth[%0d.%0d]: got %0d want %0d", t, w, d, md); end
`endif
            end
        end
    endtask

    initial begin
        test_reset();
        test_tree();
        test_root_leaf();
        test_self_loop();
        test_hold();
        test_cfg_same_cycle();
        test_cfg_during_walk();
        test_reset_mid_walk();
        test_random_trees();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
